rtc_calendar_counter: RTL and testbench

Parametrised next-generation RTC time/calendar counter. Runs from one fast system clock with an internal prescaler instead of an external 1 Hz clock. Keeps sec/min/hour/day-of-week/day-of-month/month/year with full Gregorian leap rules, live 12/24-hour display, preset load and seconds tick output. Sits between the oscillator clock domain and the RTC register bank.

---
 rtl/rtc_pkg.sv | 56 +++++
 rtl/rtc_prescaler.sv | 43 ++++
 rtl/rtc_calendar_counter.sv | 258 +++++++++++++++++++++++++
 tb/tb_rtc_calendar_counter.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared constants and calendar helpers for the RTC calendar counter.
// Year arguments are taken as 32-bit values so the helpers serve any YEAR_W up to 32.
package rtc_pkg;

  localparam int unsigned SEC_MAX   = 59;
  localparam int unsigned MIN_MAX   = 59;
  localparam int unsigned HOUR_MAX  = 23;
  localparam int unsigned DOW_MAX   = 7;
  localparam int unsigned MONTH_MAX = 12;

  localparam int unsigned MODE_12H_BIT = 0;
  localparam int unsigned MODE_PM_BIT  = 1;

  // 12 h representation of an hour: 1..12 plus PM flag
  typedef struct packed {
    logic       pm;
    logic [5:0] hour;
  } hour12_t;

  function automatic logic is_leap(input logic [31:0] year);
    return ((year % 32'd4 == 32'd0) && (year % 32'd100 != 32'd0)) || (year % 32'd400 == 32'd0);
  endfunction

  // Out-of-range months fall through to 31; callers clamp the month first
  function automatic logic [4:0] days_in_month(input logic [3:0] month, input logic [31:0] year);
    logic [4:0] days;
    case (month)
      4'd4, 4'd6, 4'd9, 4'd11: days = 5'd30;
      4'd2:                    days = is_leap(year) ? 5'd29 : 5'd28;
      default:                 days = 5'd31;
    endcase
    return days;
  endfunction

  // Expects hour12 already clamped to 1..12
  function automatic logic [5:0] hour_12_to_24(input logic [5:0] hour12, input logic pm);
    if (hour12 == 6'd12) begin
      return pm ? 6'd12 : 6'd0;
    end
    return pm ? hour12 + 6'd12 : hour12;
  endfunction

  function automatic hour12_t hour_24_to_12(input logic [5:0] hour24);
    hour12_t res;
    res.pm = (hour24 >= 6'd12);
    if (hour24 == 6'd0) begin
      res.hour = 6'd12;
    end else if (hour24 > 6'd12) begin
      res.hour = hour24 - 6'd12;
    end else begin
      res.hour = hour24;
    end
    return res;
  endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// Seconds prescaler: counts 0..TICK_DIV-1 and flags the wrap cycle.
// tick_o is combinational and marks the cycle in which the count wraps.
module rtc_prescaler #(
  parameter int unsigned TICK_DIV = 32768
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic enable_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Next count: clear wins, disabled holds the partial second
  always_comb begin
    cnt_d  = cnt_q;
    tick_o = 1'b0;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      if (cnt_q == CntLast) begin
        cnt_d  = '0;
        tick_o = 1'b1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // Count register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rtc_calendar_counter.sv
// RTC time/calendar counter with internal prescaler, Gregorian calendar, preset load
// and 12/24 h display. Time is kept internally in 24 h form; outputs are registered.
// Optional alarm comparator enabled by defining RTC_ALARM_EN.
module rtc_calendar_counter
  import rtc_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 32768,
  parameter int unsigned YEAR_W     = 12,
  parameter int unsigned RESET_YEAR = 2000
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              enable_i,
  input  logic              mode_i,
  input  logic              en_preset_i,
  input  logic [5:0]        init_sec_i,
  input  logic [5:0]        init_min_i,
  input  logic [5:0]        init_hour_i,
  input  logic [1:0]        init_mode_i,
  input  logic [2:0]        init_day_of_week_i,
  input  logic [4:0]        init_day_of_month_i,
  input  logic [3:0]        init_month_i,
  input  logic [YEAR_W-1:0] init_year_i,
  output logic [5:0]        cur_sec_o,
  output logic [5:0]        cur_min_o,
  output logic [5:0]        cur_hour_o,
  output logic [1:0]        cur_mode_o,
  output logic [2:0]        cur_day_of_week_o,
  output logic [4:0]        cur_day_of_month_o,
  output logic [3:0]        cur_month_o,
  output logic [YEAR_W-1:0] cur_year_o,
  output logic              tick_o
`ifdef RTC_ALARM_EN
  ,
  input  logic              alarm_set_i,
  input  logic [5:0]        alarm_sec_i,
  input  logic [5:0]        alarm_min_i,
  input  logic [5:0]        alarm_hour_i,
  input  logic              alarm_en_i,
  output logic              alarm_o
`endif
);

  logic tick;

  rtc_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .enable_i(enable_i),
    .clear_i (en_preset_i),
    .tick_o  (tick)
  );

  logic [5:0]        sec_q, sec_d, min_q, min_d, hour_q, hour_d;
  logic [2:0]        dow_q, dow_d;
  logic [4:0]        dom_q, dom_d;
  logic [3:0]        month_q, month_d;
  logic [YEAR_W-1:0] year_q, year_d;

  logic [5:0] p_sec, p_min, p_hour, p_hour12;
  logic [2:0] p_dow;
  logic [4:0] p_dom, p_dom_max, cur_dim;
  logic [3:0] p_month;

  // Sanitise preset fields: clamp to legal ranges and fold 12 h input into 24 h form
  always_comb begin
    p_sec    = (init_sec_i > 6'(SEC_MAX)) ? 6'(SEC_MAX) : init_sec_i;
    p_min    = (init_min_i > 6'(MIN_MAX)) ? 6'(MIN_MAX) : init_min_i;
    p_hour12 = ((init_hour_i == 6'd0) || (init_hour_i > 6'd12)) ? 6'd12 : init_hour_i;
    if (init_mode_i[MODE_12H_BIT]) begin
      p_hour = hour_12_to_24(p_hour12, init_mode_i[MODE_PM_BIT]);
    end else begin
      p_hour = (init_hour_i > 6'(HOUR_MAX)) ? 6'(HOUR_MAX) : init_hour_i;
    end
    if (init_month_i == 4'd0) begin
      p_month = 4'd1;
    end else if (init_month_i > 4'(MONTH_MAX)) begin
      p_month = 4'(MONTH_MAX);
    end else begin
      p_month = init_month_i;
    end
    p_dow     = (init_day_of_week_i == 3'd0) ? 3'd1 : init_day_of_week_i;
    // Day clamp uses the already-clamped month
    p_dom_max = days_in_month(p_month, 32'(init_year_i));
    if (init_day_of_month_i == 5'd0) begin
      p_dom = 5'd1;
    end else if (init_day_of_month_i > p_dom_max) begin
      p_dom = p_dom_max;
    end else begin
      p_dom = init_day_of_month_i;
    end
  end

  // Next time/date: preset load, else one-second cascade on tick
  always_comb begin
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    dow_d   = dow_q;
    dom_d   = dom_q;
    month_d = month_q;
    year_d  = year_q;
    cur_dim = days_in_month(month_q, 32'(year_q));
    if (en_preset_i) begin
      sec_d   = p_sec;
      min_d   = p_min;
      hour_d  = p_hour;
      dow_d   = p_dow;
      dom_d   = p_dom;
      month_d = p_month;
      year_d  = init_year_i;
    end else if (tick) begin
      if (sec_q == 6'(SEC_MAX)) begin
        sec_d = 6'd0;
        if (min_q == 6'(MIN_MAX)) begin
          min_d = 6'd0;
          if (hour_q == 6'(HOUR_MAX)) begin
            hour_d = 6'd0;
            dow_d  = (dow_q == 3'(DOW_MAX)) ? 3'd1 : dow_q + 3'd1;
            if (dom_q == cur_dim) begin
              dom_d = 5'd1;
              if (month_q == 4'(MONTH_MAX)) begin
                month_d = 4'd1;
                year_d  = year_q + YEAR_W'(1);
              end else begin
                month_d = month_q + 4'd1;
              end
            end else begin
              dom_d = dom_q + 5'd1;
            end
          end else begin
            hour_d = hour_q + 6'd1;
          end
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end
  end

  // Internal time/date state
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sec_q   <= 6'd0;
      min_q   <= 6'd0;
      hour_q  <= 6'd0;
      dow_q   <= 3'd1;
      dom_q   <= 5'd1;
      month_q <= 4'd1;
      year_q  <= YEAR_W'(RESET_YEAR);
    end else begin
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
      dow_q   <= dow_d;
      dom_q   <= dom_d;
      month_q <= month_d;
      year_q  <= year_d;
    end
  end

  hour12_t    disp;
  logic [5:0] cur_hour_d;
  logic [1:0] cur_mode_d;

  // Display conversion; mode_i only affects the view, never the stored time
  always_comb begin
    disp       = hour_24_to_12(hour_q);
    cur_hour_d = mode_i ? disp.hour : hour_q;
    cur_mode_d = 2'b00;
    cur_mode_d[MODE_12H_BIT] = mode_i;
    cur_mode_d[MODE_PM_BIT]  = mode_i & disp.pm;
  end

  logic [5:0]        cur_sec_q, cur_min_q, cur_hour_q;
  logic [1:0]        cur_mode_q;
  logic [2:0]        cur_dow_q;
  logic [4:0]        cur_dom_q;
  logic [3:0]        cur_month_q;
  logic [YEAR_W-1:0] cur_year_q;
  logic              tick_q;

  // Output registers: one cycle behind the internal state
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cur_sec_q   <= 6'd0;
      cur_min_q   <= 6'd0;
      cur_hour_q  <= 6'd0;
      cur_mode_q  <= 2'b00;
      cur_dow_q   <= 3'd1;
      cur_dom_q   <= 5'd1;
      cur_month_q <= 4'd1;
      cur_year_q  <= YEAR_W'(RESET_YEAR);
      tick_q      <= 1'b0;
    end else begin
      cur_sec_q   <= sec_q;
      cur_min_q   <= min_q;
      cur_hour_q  <= cur_hour_d;
      cur_mode_q  <= cur_mode_d;
      cur_dow_q   <= dow_q;
      cur_dom_q   <= dom_q;
      cur_month_q <= month_q;
      cur_year_q  <= year_q;
      tick_q      <= tick;
    end
  end

  assign cur_sec_o          = cur_sec_q;
  assign cur_min_o          = cur_min_q;
  assign cur_hour_o         = cur_hour_q;
  assign cur_mode_o         = cur_mode_q;
  assign cur_day_of_week_o  = cur_dow_q;
  assign cur_day_of_month_o = cur_dom_q;
  assign cur_month_o        = cur_month_q;
  assign cur_year_o         = cur_year_q;
  assign tick_o             = tick_q;

`ifdef RTC_ALARM_EN
  logic [5:0] alarm_sec_q, alarm_sec_d, alarm_min_q, alarm_min_d, alarm_hour_q, alarm_hour_d;
  logic       alarm_q, alarm_d;

  // Alarm latch and match against the post-increment time; preset never ticks, so never fires
  always_comb begin
    alarm_sec_d  = alarm_sec_q;
    alarm_min_d  = alarm_min_q;
    alarm_hour_d = alarm_hour_q;
    if (alarm_set_i) begin
      alarm_sec_d  = alarm_sec_i;
      alarm_min_d  = alarm_min_i;
      alarm_hour_d = alarm_hour_i;
    end
    alarm_d = tick && alarm_en_i && (sec_d == alarm_sec_q) && (min_d == alarm_min_q) &&
              (hour_d == alarm_hour_q);
  end

  // Alarm registers; the pulse register is aligned with tick_q
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      alarm_sec_q  <= 6'd0;
      alarm_min_q  <= 6'd0;
      alarm_hour_q <= 6'd0;
      alarm_q      <= 1'b0;
    end else begin
      alarm_sec_q  <= alarm_sec_d;
      alarm_min_q  <= alarm_min_d;
      alarm_hour_q <= alarm_hour_d;
      alarm_q      <= alarm_d;
    end
  end

  assign alarm_o = alarm_q;
`endif

endmodule

// File: tb/tb_rtc_calendar_counter.sv
// Self-checking bench for rtc_calendar_counter (TICK_DIV=4) with a seconds-of-day
// reference model. Alarm scenario is compiled in when RTC_ALARM_EN is defined.
module tb_rtc_calendar_counter;

  localparam int unsigned TickDiv   = 4;
  localparam int unsigned YearW     = 12;
  localparam int unsigned ResetYear = 2000;

  logic        clk_i = 1'b0;
  logic        rstn_i, enable_i, mode_i, en_preset_i;
  logic [5:0]  init_sec_i, init_min_i, init_hour_i;
  logic [1:0]  init_mode_i;
  logic [2:0]  init_day_of_week_i;
  logic [4:0]  init_day_of_month_i;
  logic [3:0]  init_month_i;
  logic [11:0] init_year_i;
  logic [5:0]  cur_sec_o, cur_min_o, cur_hour_o;
  logic [1:0]  cur_mode_o;
  logic [2:0]  cur_day_of_week_o;
  logic [4:0]  cur_day_of_month_o;
  logic [3:0]  cur_month_o;
  logic [11:0] cur_year_o;
  logic        tick_o;
`ifdef RTC_ALARM_EN
  logic        alarm_set_i, alarm_en_i, alarm_o;
  logic [5:0]  alarm_sec_i, alarm_min_i, alarm_hour_i;
`endif

  rtc_calendar_counter #(
    .TICK_DIV  (TickDiv),
    .YEAR_W    (YearW),
    .RESET_YEAR(ResetYear)
  ) dut (
    .clk_i              (clk_i),
    .rstn_i             (rstn_i),
    .enable_i           (enable_i),
    .mode_i             (mode_i),
    .en_preset_i        (en_preset_i),
    .init_sec_i         (init_sec_i),
    .init_min_i         (init_min_i),
    .init_hour_i        (init_hour_i),
    .init_mode_i        (init_mode_i),
    .init_day_of_week_i (init_day_of_week_i),
    .init_day_of_month_i(init_day_of_month_i),
    .init_month_i       (init_month_i),
    .init_year_i        (init_year_i),
    .cur_sec_o          (cur_sec_o),
    .cur_min_o          (cur_min_o),
    .cur_hour_o         (cur_hour_o),
    .cur_mode_o         (cur_mode_o),
    .cur_day_of_week_o  (cur_day_of_week_o),
    .cur_day_of_month_o (cur_day_of_month_o),
    .cur_month_o        (cur_month_o),
    .cur_year_o         (cur_year_o),
    .tick_o             (tick_o)
`ifdef RTC_ALARM_EN
    ,
    .alarm_set_i        (alarm_set_i),
    .alarm_sec_i        (alarm_sec_i),
    .alarm_min_i        (alarm_min_i),
    .alarm_hour_i       (alarm_hour_i),
    .alarm_en_i         (alarm_en_i),
    .alarm_o            (alarm_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  logic [44:0] dut_vec;
  assign dut_vec = {cur_sec_o, cur_min_o, cur_hour_o, cur_mode_o, cur_day_of_week_o,
                    cur_day_of_month_o, cur_month_o, cur_year_o, tick_o};

  localparam logic [44:0] ResetVec = {6'd0, 6'd0, 6'd0, 2'b00, 3'd1, 5'd1, 4'd1, 12'd2000, 1'b0};

  int          checks = 0;
  int          failures = 0;
  // Reference model: time as seconds of day plus calendar fields
  int          m_pre, m_sod, m_dow, m_dom, m_mon, m_year;
  int          alarm_sod;
  logic        m_alarm;
  logic [44:0] exp_vec;

  function automatic int dim(input int mo, input int yr);
    int days [12];
    days = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (mo == 2 && (((yr % 4 == 0) && (yr % 100 != 0)) || (yr % 400 == 0))) return 29;
    return days[mo - 1];
  endfunction

  function automatic logic [43:0] disp_vec(input logic md);
    int   h, hh;
    logic pm;
    h  = m_sod / 3600;
    hh = md ? ((h + 11) % 12) + 1 : h;
    pm = md && (h >= 12);
    return {6'(m_sod % 60), 6'((m_sod / 60) % 60), 6'(hh), pm, md, 3'(m_dow), 5'(m_dom),
            4'(m_mon), 12'(m_year)};
  endfunction

  task automatic m_reset();
    m_pre = 0; m_sod = 0; m_dow = 1; m_dom = 1; m_mon = 1; m_year = ResetYear;
    alarm_sod = 0; m_alarm = 1'b0;
    exp_vec = {disp_vec(1'b0), 1'b0};
  endtask

  task automatic m_advance();
    m_sod = m_sod + 1;
    if (m_sod == 86400) begin
      m_sod = 0;
      m_dow = (m_dow % 7) + 1;
      m_dom = m_dom + 1;
      if (m_dom > dim(m_mon, m_year)) begin
        m_dom = 1;
        m_mon = m_mon + 1;
        if (m_mon > 12) begin
          m_mon  = 1;
          m_year = (m_year + 1) % (1 << YearW);
        end
      end
    end
  endtask

  task automatic m_load();
    int s, mi, h, hh, mo, dw, dm, yr;
    s  = (init_sec_i > 59) ? 59 : int'(init_sec_i);
    mi = (init_min_i > 59) ? 59 : int'(init_min_i);
    if (init_mode_i[0]) begin
      hh = (init_hour_i == 0 || init_hour_i > 12) ? 12 : int'(init_hour_i);
      h  = (hh % 12) + (init_mode_i[1] ? 12 : 0);
    end else begin
      h = (init_hour_i > 23) ? 23 : int'(init_hour_i);
    end
    mo = (init_month_i == 0) ? 1 : ((init_month_i > 12) ? 12 : int'(init_month_i));
    yr = int'(init_year_i);
    dw = (init_day_of_week_i == 0) ? 1 : int'(init_day_of_week_i);
    dm = (init_day_of_month_i == 0) ? 1 : int'(init_day_of_month_i);
    if (dm > dim(mo, yr)) dm = dim(mo, yr);
    m_sod = h * 3600 + mi * 60 + s;
    m_dow = dw; m_dom = dm; m_mon = mo; m_year = yr;
  endtask

  // Advance model and DUT by one clock edge; exp_vec then holds the post-edge outputs
  task automatic clk_step();
    logic [43:0] shown;
    logic        tk;
    tk    = 1'b0;
    shown = disp_vec(mode_i);
    if (rstn_i) begin
      if (en_preset_i) begin
        m_load();
        m_pre = 0;
      end else if (enable_i) begin
        if (m_pre == TickDiv - 1) begin
          m_pre = 0;
          m_advance();
          tk = 1'b1;
        end else begin
          m_pre = m_pre + 1;
        end
      end
      exp_vec = {shown, tk};
`ifdef RTC_ALARM_EN
      m_alarm = tk && alarm_en_i && (m_sod == alarm_sod);
      if (alarm_set_i) alarm_sod = alarm_hour_i * 3600 + alarm_min_i * 60 + alarm_sec_i;
`endif
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_preset(input int s, input int mi, input int h, input logic [1:0] md,
                           input int dw, input int dm, input int mo, input int yr);
    init_sec_i = 6'(s); init_min_i = 6'(mi); init_hour_i = 6'(h); init_mode_i = md;
    init_day_of_week_i = 3'(dw); init_day_of_month_i = 5'(dm); init_month_i = 4'(mo);
    init_year_i = 12'(yr);
    en_preset_i = 1'b1;
    clk_step();
    en_preset_i = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (dut_vec !== ResetVec) begin
      failures++; $display("FAIL reset_state got=%h exp=%h", dut_vec, ResetVec);
    end
    rstn_i = 1'b1; enable_i = 1'b1;
    repeat (6) begin
      clk_step(); checks++;
      if (dut_vec !== exp_vec) begin
        failures++; $display("FAIL reset_count got=%h exp=%h", dut_vec, exp_vec);
      end
    end
    // Asynchronous assertion mid-count
    rstn_i = 1'b0; #1;
    checks++;
    if (dut_vec !== ResetVec) begin
      failures++; $display("FAIL reset_async_midcount got=%h exp=%h", dut_vec, ResetVec);
    end
    m_reset();
    rstn_i = 1'b1;
    do_preset(10, 11, 12, 2'b00, 3, 4, 5, 2010);
    clk_step();
    // Assertion while a preset is being requested
    en_preset_i = 1'b1; rstn_i = 1'b0; #1;
    checks++;
    if (dut_vec !== ResetVec) begin
      failures++; $display("FAIL reset_during_preset got=%h exp=%h", dut_vec, ResetVec);
    end
    m_reset();
    clk_step(); checks++;
    if (dut_vec !== ResetVec) begin
      failures++; $display("FAIL reset_hold_over_preset got=%h exp=%h", dut_vec, ResetVec);
    end
    en_preset_i = 1'b0; rstn_i = 1'b1;
  endtask

  task automatic test_year_rollover();
    int n;
    mode_i = 1'b0; enable_i = 1'b1; n = 0;
    do_preset(58, 59, 23, 2'b00, 7, 31, 12, 2021);
    repeat (10) begin
      clk_step(); checks++;
      if (dut_vec !== exp_vec) begin
        failures++; $display("FAIL rollover_cycle got=%h exp=%h", dut_vec, exp_vec);
      end
      if (tick_o) n++;
    end
    checks++;
    if (n != 2) begin failures++; $display("FAIL rollover_ticks got=%0d exp=2", n); end
    checks++;
    if ({cur_year_o, cur_month_o, cur_day_of_month_o, cur_day_of_week_o, cur_hour_o, cur_min_o,
         cur_sec_o} !== {12'd2022, 4'd1, 5'd1, 3'd1, 6'd0, 6'd0, 6'd0}) begin
      failures++;
      $display("FAIL rollover_date got=%0d-%0d-%0d dow%0d %0d:%0d:%0d exp=2022-1-1 dow1 0:0:0",
               cur_year_o, cur_month_o, cur_day_of_month_o, cur_day_of_week_o, cur_hour_o,
               cur_min_o, cur_sec_o);
    end
  endtask

  task automatic test_12h();
    mode_i = 1'b1; enable_i = 1'b1;
    do_preset(58, 59, 11, 2'b11, 3, 10, 6, 2023);
    repeat (10) begin
      clk_step(); checks++;
      if (dut_vec !== exp_vec) begin
        failures++; $display("FAIL h12_midnight_cycle got=%h exp=%h", dut_vec, exp_vec);
      end
    end
    checks++;
    if ({cur_hour_o, cur_mode_o, cur_day_of_month_o, cur_min_o, cur_sec_o} !==
        {6'd12, 2'b01, 5'd11, 6'd0, 6'd0}) begin
      failures++; $display("FAIL h12_midnight got=h%0d m%b d%0d exp=h12 m01 d11",
                           cur_hour_o, cur_mode_o, cur_day_of_month_o);
    end
    do_preset(58, 59, 12, 2'b01, 3, 10, 6, 2023);
    repeat (10) begin
      clk_step(); checks++;
      if (dut_vec !== exp_vec) begin
        failures++; $display("FAIL h12_one_am_cycle got=%h exp=%h", dut_vec, exp_vec);
      end
    end
    checks++;
    if ({cur_hour_o, cur_mode_o, cur_min_o, cur_sec_o} !== {6'd1, 2'b01, 6'd0, 6'd0}) begin
      failures++; $display("FAIL h12_one_am got=h%0d m%b exp=h1 m01", cur_hour_o, cur_mode_o);
    end
  endtask

  task automatic test_leap();
    int yrs [4];
    int exp_md [4];
    yrs    = '{2004, 2100, 2000, 4095};
    exp_md = '{2 * 32 + 29, 3 * 32 + 1, 2 * 32 + 29, 1 * 32 + 1};
    mode_i = 1'b0; enable_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) do_preset(59, 59, 23, 2'b00, 2, 31, 12, yrs[i]);
      else        do_preset(59, 59, 23, 2'b00, 2, 28, 2, yrs[i]);
      repeat (6) begin
        clk_step(); checks++;
        if (dut_vec !== exp_vec) begin
          failures++; $display("FAIL leap_cycle y%0d got=%h exp=%h", yrs[i], dut_vec, exp_vec);
        end
      end
      checks++;
      if ({cur_month_o, cur_day_of_month_o} !== 9'(exp_md[i])) begin
        failures++; $display("FAIL leap_day y%0d got=%0d/%0d exp=%0d/%0d", yrs[i], cur_month_o,
                             cur_day_of_month_o, exp_md[i] / 32, exp_md[i] % 32);
      end
    end
    checks++;
    if (cur_year_o !== 12'd0) begin
      failures++; $display("FAIL year_wrap got=%0d exp=0", cur_year_o);
    end
  endtask

  task automatic test_enable_hold();
    int n;
    logic got;
    mode_i = 1'b0; enable_i = 1'b1;
    do_preset(30, 20, 10, 2'b00, 1, 1, 1, 2020);
    repeat (2) clk_step();
    enable_i = 1'b0;
    repeat (10) begin
      clk_step(); checks++;
      if (dut_vec !== exp_vec) begin
        failures++; $display("FAIL enable_hold_cycle got=%h exp=%h", dut_vec, exp_vec);
      end
    end
    checks++;
    if (cur_sec_o !== 6'd30) begin failures++; $display("FAIL enable_hold got=%0d exp=30", cur_sec_o); end
    enable_i = 1'b1; n = 0; got = 1'b0;
    while (!got && n < 8) begin
      clk_step(); n++; checks++;
      if (dut_vec !== exp_vec) begin
        failures++; $display("FAIL enable_resume_cycle got=%h exp=%h", dut_vec, exp_vec);
      end
      if (tick_o) got = 1'b1;
    end
    checks++;
    if (n != 2) begin failures++; $display("FAIL enable_resume_latency got=%0d exp=2", n); end
    clk_step(); checks++;
    if (cur_sec_o !== 6'd31) begin failures++; $display("FAIL enable_resume_sec got=%0d exp=31", cur_sec_o); end
  endtask

  task automatic test_mode_toggle();
    enable_i = 1'b0; mode_i = 1'b0;
    do_preset(0, 0, 15, 2'b00, 1, 1, 1, 2020);
    clk_step(); checks++;
    if ({cur_hour_o, cur_mode_o} !== {6'd15, 2'b00}) begin
      failures++; $display("FAIL mode_24h got=h%0d m%b exp=h15 m00", cur_hour_o, cur_mode_o);
    end
    mode_i = 1'b1;
    clk_step(); checks++;
    if ({cur_hour_o, cur_mode_o} !== {6'd3, 2'b11}) begin
      failures++; $display("FAIL mode_to_12h got=h%0d m%b exp=h3 m11", cur_hour_o, cur_mode_o);
    end
    mode_i = 1'b0;
    clk_step(); checks++;
    if (dut_vec !== exp_vec) begin
      failures++; $display("FAIL mode_back_24h got=%h exp=%h", dut_vec, exp_vec);
    end
  endtask

  task automatic test_clamp();
    enable_i = 1'b0; mode_i = 1'b0;
    do_preset(63, 45, 30, 2'b00, 0, 31, 15, 2021);
    clk_step(); checks++;
    if ({cur_sec_o, cur_min_o, cur_hour_o, cur_month_o, cur_day_of_month_o, cur_day_of_week_o} !==
        {6'd59, 6'd45, 6'd23, 4'd12, 5'd31, 3'd1}) begin
      failures++; $display("FAIL clamp_fields got=%h exp=%h", dut_vec, exp_vec);
    end
    do_preset(0, 0, 0, 2'b00, 1, 31, 2, 2021);
    clk_step(); checks++;
    if (cur_day_of_month_o !== 5'd28) begin
      failures++; $display("FAIL clamp_feb_dom got=%0d exp=28", cur_day_of_month_o);
    end
    do_preset(0, 0, 14, 2'b11, 1, 1, 1, 2021);
    clk_step(); checks++;
    if (cur_hour_o !== 6'd12) begin
      failures++; $display("FAIL clamp_12h_pm got=%0d exp=12", cur_hour_o);
    end
    do_preset(0, 0, 0, 2'b01, 1, 1, 1, 2021);
    clk_step(); checks++;
    if (cur_hour_o !== 6'd0) begin
      failures++; $display("FAIL clamp_12h_zero got=%0d exp=0", cur_hour_o);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      enable_i = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) mode_i = ~mode_i;
      en_preset_i = ($urandom_range(0, 29) == 0);
      if (en_preset_i) begin
        init_sec_i          = 6'($urandom_range(50, 63));
        init_min_i          = 6'($urandom_range(55, 63));
        init_hour_i         = 6'($urandom_range(0, 31));
        init_mode_i         = 2'($urandom_range(0, 3));
        init_day_of_week_i  = 3'($urandom_range(0, 7));
        init_day_of_month_i = 5'(($urandom_range(0, 3) == 0) ? 0 : $urandom_range(26, 31));
        init_month_i        = 4'($urandom_range(0, 15));
        init_year_i         = 12'(($urandom_range(0, 1) == 0) ? $urandom_range(0, 4095)
                                                               : 1900 + 100 * $urandom_range(0, 3));
      end
      clk_step(); checks++;
      if (dut_vec !== exp_vec) begin
        failures++; $display("FAIL random_cycle%0d got=%h exp=%h", c, dut_vec, exp_vec);
      end
    end
    en_preset_i = 1'b0;
  endtask

`ifdef RTC_ALARM_EN
  task automatic test_alarm();
    int n;
    rstn_i = 1'b0; enable_i = 1'b0; #1;
    m_reset();
    clk_step();
    rstn_i = 1'b1;
    alarm_set_i = 1'b1; alarm_sec_i = 6'd5; alarm_min_i = 6'd0; alarm_hour_i = 6'd0;
    alarm_en_i = 1'b1;
    clk_step();
    alarm_set_i = 1'b0; enable_i = 1'b1; n = 0;
    repeat (30) begin
      clk_step();
      if (tick_o) n++;
      checks++;
      if (alarm_o !== (tick_o && n == 5)) begin
        failures++; $display("FAIL alarm_pulse tick%0d got=%b exp=%b", n, alarm_o, tick_o && n == 5);
      end
      checks++;
      if (alarm_o !== m_alarm) begin
        failures++; $display("FAIL alarm_model got=%b exp=%b", alarm_o, m_alarm);
      end
    end
    alarm_en_i = 1'b0;
  endtask
`endif

  initial begin
    rstn_i = 1'b0; enable_i = 1'b0; mode_i = 1'b0; en_preset_i = 1'b0;
    init_sec_i = '0; init_min_i = '0; init_hour_i = '0; init_mode_i = '0;
    init_day_of_week_i = '0; init_day_of_month_i = '0; init_month_i = '0; init_year_i = '0;
`ifdef RTC_ALARM_EN
    alarm_set_i = 1'b0; alarm_en_i = 1'b0; alarm_sec_i = '0; alarm_min_i = '0; alarm_hour_i = '0;
`endif
    m_reset();
    repeat (2) @(posedge clk_i);
    #1;
    test_reset();
    test_year_rollover();
    test_12h();
    test_leap();
    test_enable_hold();
    test_mode_toggle();
    test_clamp();
    test_random();
`ifdef RTC_ALARM_EN
    test_alarm();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

endmodule
